// File: rtl/unidade_controle.sv
// unidade_controle: multi-cycle Moore control FSM for the 8-bit processor.
// Decodes the instruction register and sequences PC, IR, register file,
// memory and ALU (ula) operations one state per clock.

`ifndef ULA_ADD
`define ULA_ADD 3'b000
`endif
`ifndef ULA_SUB
`define ULA_SUB 3'b001
`endif
`ifndef ULA_SLL
`define ULA_SLL 3'b010
`endif
`ifndef ULA_SRL
`define ULA_SRL 3'b011
`endif
`ifndef ULA_SLT
`define ULA_SLT 3'b100
`endif

module unidade_controle #(
   parameter int PC_W = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] instr,
   input  logic       zero,
   output logic [2:0] ctrl_ula,
   output logic       pc_write,
   output logic       pc_src,
   output logic       addr_sel,
   output logic       ir_write,
   output logic       mem_write,
   output logic       reg_write,
   output logic       wb_sel,
   output logic       halted,
   output logic [2:0] state
);

   // PC_W only documents the address width seen by the datapath.
   if (PC_W < 1) begin : g_pc_w_invalid
      $error("PC_W must be positive");
   end

   typedef enum logic [2:0] {
      FETCH   = 3'd0,
      DECODE  = 3'd1,
      EXEC    = 3'd2,
      WB_ALU  = 3'd3,
      MEM_RD  = 3'd4,
      MEM_WR  = 3'd5,
      BR_TAKE = 3'd6,
      HALT    = 3'd7
   } state_t;

   localparam logic [2:0] OP_LW  = 3'b101;
   localparam logic [2:0] OP_SW  = 3'b110;
   localparam logic [2:0] OP_SYS = 3'b111;

   state_t     cur_state;
   state_t     nxt_state;
   logic [2:0] opcode;
   logic       sub_op;
   logic       unused_fields;

   assign opcode        = instr[7:5];
   assign sub_op        = instr[0];
   assign unused_fields = ^instr[4:1];   // rd/rs select datapath registers only
   assign state         = cur_state;

   // Maps an ALU opcode to its ula operation code.
   function automatic logic [2:0] alu_op(input logic [2:0] op);
      case (op)
         3'b000:  alu_op = `ULA_ADD;
         3'b001:  alu_op = `ULA_SUB;
         3'b010:  alu_op = `ULA_SLL;
         3'b011:  alu_op = `ULA_SRL;
         3'b100:  alu_op = `ULA_SLT;
         default: alu_op = `ULA_ADD;
      endcase
   endfunction

   // State register; reset returns to FETCH and abandons any instruction.
   always_ff @(posedge clk) begin
      if (rst) cur_state <= FETCH;
      else     cur_state <= nxt_state;
   end

   // Next-state and Moore outputs from state and IR contents.
   always_comb begin
      nxt_state = cur_state;
      ctrl_ula  = `ULA_ADD;
      pc_write  = 1'b0;
      pc_src    = 1'b0;
      addr_sel  = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      wb_sel    = 1'b0;
      halted    = 1'b0;

      case (cur_state)
         FETCH: begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            nxt_state = DECODE;
         end
         DECODE: begin
            case (opcode)
               OP_LW:   nxt_state = MEM_RD;
               OP_SW:   nxt_state = MEM_WR;
               OP_SYS:  nxt_state = sub_op ? HALT : EXEC;
               default: nxt_state = EXEC;
            endcase
         end
         EXEC: begin
            if (opcode == OP_SYS) begin
               // BEQ: compare via subtraction; not-taken skips the target byte here.
               ctrl_ula = `ULA_SUB;
               if (zero) begin
                  nxt_state = BR_TAKE;
               end else begin
                  pc_write  = 1'b1;
                  nxt_state = FETCH;
               end
            end else begin
               ctrl_ula  = alu_op(opcode);
               nxt_state = WB_ALU;
            end
         end
         WB_ALU: begin
            ctrl_ula  = alu_op(opcode);
            reg_write = 1'b1;
            nxt_state = FETCH;
         end
         MEM_RD: begin
            addr_sel  = 1'b1;
            reg_write = 1'b1;
            wb_sel    = 1'b1;
            nxt_state = FETCH;
         end
         MEM_WR: begin
            addr_sel  = 1'b1;
            mem_write = 1'b1;
            nxt_state = FETCH;
         end
         BR_TAKE: begin
            pc_write  = 1'b1;
            pc_src    = 1'b1;
            nxt_state = FETCH;
         end
         HALT: begin
            halted = 1'b1;
         end
         default: nxt_state = FETCH;
      endcase

      // Reset suppresses every write so an abandoned instruction leaves no trace.
      if (rst) begin
         pc_write  = 1'b0;
         ir_write  = 1'b0;
         reg_write = 1'b0;
         mem_write = 1'b0;
         ctrl_ula  = `ULA_ADD;
         halted    = 1'b0;
      end
   end

endmodule

// File: tb/tb_unidade_controle.sv
// Self-checking bench for unidade_controle: per-instruction expected traces
// are built from the instruction semantics and compared cycle by cycle.

module tb_unidade_controle;

   logic       clk;
   logic       rst;
   logic [7:0] instr;
   logic       zero;
   logic [2:0] ctrl_ula;
   logic       pc_write;
   logic       pc_src;
   logic       addr_sel;
   logic       ir_write;
   logic       mem_write;
   logic       reg_write;
   logic       wb_sel;
   logic       halted;
   logic [2:0] state;

   int checks = 0;
   int errors = 0;

   // record layout: {state[2:0], ctrl[2:0], pc_write, pc_src, addr_sel, ir_write, mem_write, reg_write, wb_sel, halted}
   logic [13:0] exp_q[$];

   unidade_controle #(.PC_W(8)) dut (
      .clk(clk), .rst(rst), .instr(instr), .zero(zero),
      .ctrl_ula(ctrl_ula), .pc_write(pc_write), .pc_src(pc_src),
      .addr_sel(addr_sel), .ir_write(ir_write), .mem_write(mem_write),
      .reg_write(reg_write), .wb_sel(wb_sel), .halted(halted), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [13:0] rec(input int st, input int ctrl,
                                       input bit pcw, input bit pcs, input bit as,
                                       input bit irw, input bit mw, input bit rw,
                                       input bit wb, input bit h);
      logic [2:0] s3;
      logic [2:0] c3;
      s3 = st[2:0];
      c3 = ctrl[2:0];
      return {s3, c3, pcw, pcs, as, irw, mw, rw, wb, h};
   endfunction

   function automatic logic [13:0] observed();
      return {state, ctrl_ula, pc_write, pc_src, addr_sel, ir_write,
              mem_write, reg_write, wb_sel, halted};
   endfunction

   // Expected per-cycle behaviour of one instruction, starting at its fetch.
   function automatic void build_trace(input logic [7:0] ins, input bit z_exec);
      int op;
      op = int'(ins[7:5]);
      exp_q.delete();
      exp_q.push_back(rec(0, 0, 1, 0, 0, 1, 0, 0, 0, 0));      // fetch
      exp_q.push_back(rec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));      // decode
      if (op <= 4) begin                                       // ADD SUB SLL SRL SLT -> ula codes 0..4
         exp_q.push_back(rec(2, op, 0, 0, 0, 0, 0, 0, 0, 0));
         exp_q.push_back(rec(3, op, 0, 0, 0, 0, 0, 1, 0, 0));
      end else if (op == 5) begin                              // LW
         exp_q.push_back(rec(4, 0, 0, 0, 1, 0, 0, 1, 1, 0));
      end else if (op == 6) begin                              // SW
         exp_q.push_back(rec(5, 0, 0, 0, 1, 0, 1, 0, 0, 0));
      end else if (ins[0] == 1'b0) begin                       // BEQ
         exp_q.push_back(rec(2, 1, !z_exec, 0, 0, 0, 0, 0, 0, 0));
         if (z_exec) exp_q.push_back(rec(6, 0, 1, 1, 0, 0, 0, 0, 0, 0));
      end else begin                                           // HALT
         exp_q.push_back(rec(7, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      end
   endfunction

   // Runs one instruction from its fetch cycle (caller is inside that cycle).
   // zero is random except in cycle 2, where BEQ samples it. Stops after
   // max_cyc cycles when max_cyc >= 0.
   task automatic run_instr(input logic [7:0] ins, input bit z_exec, input int max_cyc,
                            input string name);
      logic [13:0] obs;
      int n;
      build_trace(ins, z_exec);
      n = exp_q.size();
      if (max_cyc >= 0 && max_cyc < n) n = max_cyc;
      for (int i = 0; i < n; i++) begin
         instr = ins;
         zero  = (i == 2) ? z_exec : 1'($urandom);
         #1;
         obs = observed();
         checks++;
         if (obs !== exp_q[i]) begin
            errors++;
            $display("FAIL %s instr=%h cyc=%0d got=%b expected=%b", name, ins, i, obs, exp_q[i]);
         end
         checks++;
         if (pc_write && (reg_write || mem_write)) begin
            errors++;
            $display("FAIL %s_overlap instr=%h cyc=%0d got pcw=%b rw=%b mw=%b expected no overlap",
                     name, ins, i, pc_write, reg_write, mem_write);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; instr = 8'h0A; zero = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (state !== 3'd0 || pc_write !== 1'b0 || ir_write !== 1'b0 || reg_write !== 1'b0 ||
          mem_write !== 1'b0 || halted !== 1'b0 || ctrl_ula !== 3'd0) begin
         errors++;
         $display("FAIL reset_hold got state=%0d pcw=%b irw=%b rw=%b mw=%b h=%b ctrl=%0d expected 0 all",
                  state, pc_write, ir_write, reg_write, mem_write, halted, ctrl_ula);
      end
      rst = 1'b0; #1;
      run_instr(8'h0A, 1'b0, 3, "reset_pre");   // up to and including EXEC
      // now in WB_ALU; assert reset before the write can happen
      rst = 1'b1; #1;
      checks++;
      if (reg_write !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_wb got reg_write=%b expected 0", reg_write);
      end
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         checks++;
         if (reg_write !== 1'b0 || pc_write !== 1'b0 || ir_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_held cyc=%0d got rw=%b pcw=%b irw=%b expected 0", i,
                     reg_write, pc_write, ir_write);
         end
      end
      rst = 1'b0; #1;
      checks++;
      if (state !== 3'd0 || ir_write !== 1'b1 || pc_write !== 1'b1) begin
         errors++;
         $display("FAIL reset_release got state=%0d irw=%b pcw=%b expected 0 1 1",
                  state, ir_write, pc_write);
      end
   endtask

   task automatic test_alu();
      logic [7:0] ins;
      run_instr(8'h0A, 1'b0, -1, "add");
      for (int op = 1; op <= 4; op++) begin
         ins = {op[2:0], 5'($urandom)};
         run_instr(ins, 1'($urandom), -1, "alu");
      end
   endtask

   task automatic test_mem();
      run_instr(8'hAC, 1'b1, -1, "lw");
      run_instr(8'hCC, 1'b0, -1, "sw");
      run_instr(8'hCC, 1'b1, -1, "sw_z");
   endtask

   task automatic test_branch();
      run_instr(8'hE2, 1'b1, -1, "beq_taken");
      run_instr(8'hE2, 1'b0, -1, "beq_not_taken");
   endtask

   task automatic test_back_to_back();
      logic [7:0] ins;
      for (int k = 0; k < 40; k++) begin
         ins = 8'($urandom);
         if (ins[7:5] == 3'b111) ins[0] = 1'b0;   // keep HALT out of the random stream
         run_instr(ins, 1'($urandom), -1, "random");
      end
   endtask

   task automatic test_halt();
      run_instr(8'hFF, 1'b0, 3, "halt_enter");   // fetch, decode, first HALT cycle
      for (int i = 0; i < 50; i++) begin
         instr = 8'($urandom);
         zero  = 1'($urandom);
         #1;
         checks++;
         if (state !== 3'd7 || halted !== 1'b1 || pc_write !== 1'b0 || ir_write !== 1'b0 ||
             reg_write !== 1'b0 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL halt_stay cyc=%0d got state=%0d h=%b pcw=%b irw=%b rw=%b mw=%b expected 7 1 0 0 0 0",
                     i, state, halted, pc_write, ir_write, reg_write, mem_write);
         end
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; #1;
      checks++;
      if (state !== 3'd0 || halted !== 1'b0 || ir_write !== 1'b1) begin
         errors++;
         $display("FAIL halt_exit got state=%0d h=%b irw=%b expected 0 0 1", state, halted, ir_write);
      end
   endtask

   initial begin
      rst = 1'b1; instr = 8'h00; zero = 1'b0;
      test_reset();
      test_alu();
      test_mem();
      test_branch();
      test_back_to_back();
      test_halt();
      run_instr(8'h2B, 1'b1, -1, "after_halt");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
